// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back controller.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  // Index of the hardwired-zero register.
  localparam int X0 = 0;

  // Write-port requesters; the value doubles as the grant/request bit index.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Grant is combinational; the last-winner
// pointer only moves when the granted request is actually accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  import regfile_pkg::*;

  req_e last_reg;

  // Single requester wins outright; on a tie the one not granted last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_reg == REQ_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner of each completed handshake; reset favours the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= REQ_LSU;
    end else if (accept) begin
      last_reg <= gnt[1] ? REQ_LSU : REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: shares the register file's single write port between
// the ALU and the LSU, tracks outstanding writes per register and stalls issue
// on RAW/WAW hazards.
module regfile_wb_ctrl #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREG   = regfile_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rs1,
  input  logic [ADDR_W-1:0] iss_rs2,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_wd,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_wd,
  output logic              lsu_ready,
  output logic              regwrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] wd,
  output logic [NREG-1:0]   busy
);
  import regfile_pkg::*;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              handshake;
  logic              iss_accept;
  logic [ADDR_W-1:0] req_rd;
  logic [DATA_W-1:0] req_wd;
  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;
  logic [NREG-1:0]   busy_dly_reg;
  logic [NREG-1:0]   hazard;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;

  assign req = {lsu_valid, alu_valid};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (handshake),
    .gnt    (gnt)
  );

  assign alu_ready = gnt[REQ_ALU];
  assign lsu_ready = gnt[REQ_LSU];
  assign handshake = |(req & gnt);
  assign req_rd    = gnt[REQ_LSU] ? lsu_rd : alu_rd;
  assign req_wd    = gnt[REQ_LSU] ? lsu_wd : alu_wd;

  // A newly set bit stalls at once, but a cleared bit keeps stalling for one
  // more cycle so the dependant reads the register file after it is written.
  assign hazard     = busy_reg | busy_dly_reg;
  assign iss_stall  = iss_valid & (hazard[iss_rs1] | hazard[iss_rs2] | hazard[iss_rd]);
  assign iss_accept = iss_valid & ~iss_stall;

  // x0 never becomes busy.
  assign set_vec[X0]   = 1'b0;
  assign clr_vec[X0]   = 1'b0;
  assign busy_next[X0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_sb
      assign set_vec[gi]   = iss_accept && (iss_rd == ADDR_W'(gi));
      assign clr_vec[gi]   = handshake && (req_rd == ADDR_W'(gi));
      // Set beats clear when an issue and a write hit the same register.
      assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
    end
  endgenerate

  assign busy = busy_reg;

  // Scoreboard and its one-cycle-delayed copy used for release timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg     <= '0;
      busy_dly_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      busy_dly_reg <= busy_reg;
    end
  end

  // Register-file write port: one-cycle write pulse, index/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite <= 1'b0;
      rd       <= '0;
      wd       <= '0;
    end else begin
      regwrite <= handshake && (req_rd != ADDR_W'(X0));
      if (handshake) begin
        rd <= req_rd;
        wd <= req_wd;
      end
    end
  end

endmodule
